fifo_ctl: RTL and testbench

Parametrised synchronous FIFO with first-word-fall-through output, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the next-generation buffer behind the UART TX/RX paths, replacing the plain full/empty FIFO. It adds level reporting and threshold flags, which drive interrupt and flow-control logic, plus error capture for misuse of the handshake.

---
 rtl/fifo_ctl.sv | 131 +++++++++++++
 tb/tb_fifo_ctl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fifo_ctl.sv
// fifo_ctl -- synchronous first-word-fall-through FIFO with occupancy level,
// almost-full / almost-empty thresholds and sticky handshake-error flags.
//
// Optional feature macro: FIFO_CTL_ERR_EN
//   defined   : ovf/udf are sticky error registers, cleared by clr_err
//   undefined : ovf/udf tied to 0, clr_err ignored, no error registers
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-low reset
//   idata    in   write data (WIDTH)
//   wr_en    in   push request, dropped while full
//   next     in   pop request for the word on odata, dropped while empty
//   clr_err  in   clears ovf/udf
//   odata    out  head-of-queue word, valid while empty=0
//   full     out  level == DEPTH
//   empty    out  level == 0
//   afull    out  level >= AF_LEVEL
//   aempty   out  level <= AE_LEVEL
//   level    out  occupancy 0..DEPTH (NCBIT+1 bits)
//   ovf      out  sticky: push attempted while full
//   udf      out  sticky: pop attempted while empty
module fifo_ctl #(
   parameter int WIDTH    = 8,
   parameter int NCBIT    = 4,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] idata,
   input  logic             wr_en,
   input  logic             next,
   input  logic             clr_err,
   output logic [WIDTH-1:0] odata,
   output logic             full,
   output logic             empty,
   output logic             afull,
   output logic             aempty,
   output logic [NCBIT:0]   level,
   output logic             ovf,
   output logic             udf
);

   localparam int DEPTH = 1 << NCBIT;
   localparam logic [NCBIT:0]   LV_ONE   = (NCBIT+1)'(1);
   localparam logic [NCBIT:0]   LV_DEPTH = (NCBIT+1)'(DEPTH);
   localparam logic [NCBIT:0]   LV_AF    = (NCBIT+1)'(AF_LEVEL);
   localparam logic [NCBIT:0]   LV_AE    = (NCBIT+1)'(AE_LEVEL);
   localparam logic [NCBIT-1:0] PT_ONE   = NCBIT'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [NCBIT-1:0] r_wp, r_rp;
   logic [NCBIT:0]   r_level;
   logic             r_full, r_empty, r_afull, r_aempty;

   logic             w_wa, w_ra;
   logic [NCBIT:0]   w_level_nxt;

   // Accept decisions use the registered flags, so push+pop while full drops
   // the push and push+pop while empty drops the pop.
   assign w_wa = wr_en & ~r_full;
   assign w_ra = next  & ~r_empty;

   always_comb begin
      w_level_nxt = r_level;
      if (w_wa && !w_ra)
         w_level_nxt = r_level + LV_ONE;
      else if (w_ra && !w_wa)
         w_level_nxt = r_level - LV_ONE;
   end

   // Storage is not reset; a push coinciding with reset is discarded.
   always_ff @(posedge clk) begin
      if (rst && w_wa)
         r_mem[r_wp] <= idata;
   end

   // Flags are computed from the next-state level so they always agree with
   // the registered level in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wp     <= '0;
         r_rp     <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
      end else begin
         if (w_wa) r_wp <= r_wp + PT_ONE;
         if (w_ra) r_rp <= r_rp + PT_ONE;
         r_level  <= w_level_nxt;
         r_full   <= (w_level_nxt == LV_DEPTH);
         r_empty  <= (w_level_nxt == '0);
         r_afull  <= (w_level_nxt >= LV_AF);
         r_aempty <= (w_level_nxt <= LV_AE);
      end
   end

`ifdef FIFO_CTL_ERR_EN
   logic r_ovf, r_udf;

   // A new error in the same cycle as clr_err wins: the flag ends set.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= (r_ovf & ~clr_err) | (wr_en & r_full);
         r_udf <= (r_udf & ~clr_err) | (next  & r_empty);
      end
   end

   assign ovf = r_ovf;
   assign udf = r_udf;
`else
   logic w_unused_clr;
   assign w_unused_clr = clr_err;
   assign ovf = 1'b0;
   assign udf = 1'b0;
`endif

   assign odata  = r_mem[r_rp];
   assign full   = r_full;
   assign empty  = r_empty;
   assign afull  = r_afull;
   assign aempty = r_aempty;
   assign level  = r_level;

endmodule

// File: tb/tb_fifo_ctl.sv
// tb_fifo_ctl -- directed self-checking bench for fifo_ctl with default
// parameters (WIDTH=8, NCBIT=4, AF_LEVEL=12, AE_LEVEL=2).
module tb_fifo_ctl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] idata = '0;
   logic       wr_en = 1'b0;
   logic       next = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] odata;
   logic       full, empty, afull, aempty, ovf, udf;
   logic [4:0] level;

   int n_chk = 0;
   int n_bad = 0;

`ifdef FIFO_CTL_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   fifo_ctl dut (
      .clk(clk), .rst(rst), .idata(idata), .wr_en(wr_en), .next(next),
      .clr_err(clr_err), .odata(odata), .full(full), .empty(empty),
      .afull(afull), .aempty(aempty), .level(level), .ovf(ovf), .udf(udf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en = 1'b1; idata = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pop();
      next = 1'b1;
      tick();
      next = 1'b0;
   endtask

   initial begin
      // reset held 2 cycles
      tick(); tick();
      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_aempty", aempty, 1);
      chk("rst_full", full, 0);
      chk("rst_afull", afull, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_udf", udf, 0);
      rst = 1'b1;

      // first write falls through
      push(8'h01);
      chk("w1_empty", empty, 0);
      chk("w1_level", level, 1);
      chk("w1_odata", odata, 8'h01);
      pop();
      chk("w1_pop_empty", empty, 1);
      chk("w1_pop_level", level, 0);

      // fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         chk("fill_level", level, i+1);
         chk("fill_afull", afull, (i+1 >= 12) ? 1 : 0);
         chk("fill_full", full, (i+1 == 16) ? 1 : 0);
      end
      // drain, expecting write order
      for (int i = 0; i < 16; i++) begin
         chk("drain_odata", odata, i);
         pop();
         chk("drain_level", level, 15-i);
         chk("drain_aempty", aempty, (15-i <= 2) ? 1 : 0);
         chk("drain_empty", empty, (i == 15) ? 1 : 0);
         chk("drain_full", full, 0);
      end

      // overflow: push+pop while full drops the push
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      chk("ovf_pre_full", full, 1);
      wr_en = 1'b1; next = 1'b1; idata = 8'hAA;
      tick();
      wr_en = 1'b0; next = 1'b0;
      chk("ovf_level", level, 15);
      chk("ovf_full", full, 0);
      chk("ovf_flag", ovf, ERR_ON);
      chk("ovf_head", odata, 8'h11);
      tick();
      chk("ovf_sticky", ovf, ERR_ON);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("ovf_clr", ovf, 0);
      for (int i = 0; i < 15; i++) begin
         chk("ovf_drain", odata, 8'h11 + i);
         pop();
      end
      chk("ovf_drained_empty", empty, 1);

      // underflow: push+pop while empty drops the pop
      wr_en = 1'b1; next = 1'b1; idata = 8'h55;
      tick();
      wr_en = 1'b0; next = 1'b0;
      chk("udf_level", level, 1);
      chk("udf_odata", odata, 8'h55);
      chk("udf_flag", udf, ERR_ON);
      chk("udf_ovf_clean", ovf, 0);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("udf_clr", udf, 0);
      pop();
      chk("udf_pop_empty", empty, 1);

      // streaming: prefill 4, then push+pop every cycle for 40 cycles
      for (int i = 0; i < 4; i++) push(8'(8'h80 + i));
      for (int k = 0; k < 40; k++) begin
         chk("strm_odata", odata, 8'h80 + k);
         wr_en = 1'b1; next = 1'b1; idata = 8'(8'h84 + k);
         tick();
         chk("strm_level", level, 4);
      end
      wr_en = 1'b0; next = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("strm_tail", odata, 8'hA8 + i);
         pop();
      end
      chk("strm_empty", empty, 1);

      // reset mid-operation discards contents and the concurrent write
      for (int i = 0; i < 9; i++) push(8'(8'hC0 + i));
      chk("mid_level", level, 9);
      rst = 1'b0; wr_en = 1'b1; idata = 8'hEE;
      tick();
      rst = 1'b1; wr_en = 1'b0;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_aempty", aempty, 1);
      push(8'h3C);
      chk("mid_post_odata", odata, 8'h3C);
      chk("mid_post_level", level, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
